// File: rtl/cmd_issuer_pkg.sv
// cmd_issuer_pkg: shared state encoding, bus instruction codes and sizing helper
package cmd_issuer_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WR, WAIT_RD} state_t;

    localparam logic [1:0] INSTR_IDLE  = 2'b00;
    localparam logic [1:0] INSTR_WRITE = 2'b10;
    localparam logic [1:0] INSTR_READ  = 2'b11;

    function automatic int msel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmd_issuer_if.sv
// cmd_issuer_if: flattened per-master command bus, master 0 in the LSBs of every field
interface cmd_issuer_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_LEN    = 12,
    parameter int DATA_LEN    = 8,
    parameter int BURST_LEN   = 12,
    parameter int SLAVE_LEN   = 2
);
    logic [NUM_MASTERS*ADDR_LEN-1:0]  address_m;
    logic [NUM_MASTERS*DATA_LEN-1:0]  data_m;
    logic [NUM_MASTERS*BURST_LEN-1:0] burst_num_m;
    logic [NUM_MASTERS*SLAVE_LEN-1:0] slave_select_m;
    logic [NUM_MASTERS*2-1:0]         instruction_m;
    logic [NUM_MASTERS-1:0]           tx_done_m;
    logic [NUM_MASTERS-1:0]           rx_done_m;
    logic [NUM_MASTERS-1:0]           new_rx_m;
    logic [NUM_MASTERS*DATA_LEN-1:0]  new_data_m;

    modport master (
        output address_m, data_m, burst_num_m, slave_select_m, instruction_m,
        input  tx_done_m, rx_done_m, new_rx_m, new_data_m
    );

    modport slave (
        input  address_m, data_m, burst_num_m, slave_select_m, instruction_m,
        output tx_done_m, rx_done_m, new_rx_m, new_data_m
    );
endinterface

// File: rtl/cmd_issuer_btn_sync.sv
// btn_sync_edge: two-flop synchroniser for a raw button with a registered one-clock rising-edge pulse
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    logic [2:0] sync;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sync  <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[1:0], btn};
            pulse <= sync[1] & ~sync[2];
        end
endmodule

// File: rtl/cmd_issuer.sv
// cmd_issuer: button-triggered single command issuer onto one of several bus masters,
// with read-beat capture, completion timeout and abort
module cmd_issuer
    import cmd_issuer_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_LEN       = 12,
    parameter int DATA_LEN       = 8,
    parameter int BURST_LEN      = 12,
    parameter int SLAVE_LEN      = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int MSEL_W        = msel_width(NUM_MASTERS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_LEN-1:0]  cmd_addr,
    input  logic [DATA_LEN-1:0]  cmd_data,
    input  logic [BURST_LEN-1:0] cmd_burst,
    input  logic [SLAVE_LEN-1:0] cmd_slave,
    input  logic                 cmd_read,
    input  logic [MSEL_W-1:0]    cmd_master,
    input  logic                 btn_go,
    input  logic                 btn_abort,
    cmd_issuer_if.master         bus,
    output logic [DATA_LEN-1:0]  read_data,
    output logic [BURST_LEN-1:0] beat_count,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic                 go_p, abort_p;
    logic [ADDR_LEN-1:0]  sh_addr;
    logic [DATA_LEN-1:0]  sh_data;
    logic [BURST_LEN-1:0] sh_burst;
    logic [SLAVE_LEN-1:0] sh_slave;
    logic                 sh_read;
    logic [MSEL_W-1:0]    sh_master;
    logic [CNT_W-1:0]     cnt;
    logic [31:0]          sel;
    logic                 tx_sel, rx_sel, nrx_sel, fin;
    logic [DATA_LEN-1:0]  nrx_data;

    btn_sync_edge u_go    (.clk(clk), .reset(reset), .btn(btn_go),    .pulse(go_p));
    btn_sync_edge u_abort (.clk(clk), .reset(reset), .btn(btn_abort), .pulse(abort_p));

    assign sel      = 32'(sh_master);
    assign tx_sel   = bus.tx_done_m[sh_master];
    assign rx_sel   = bus.rx_done_m[sh_master];
    assign nrx_sel  = bus.new_rx_m[sh_master];
    assign nrx_data = bus.new_data_m[sel*DATA_LEN +: DATA_LEN];
    assign fin      = (state == WAIT_RD) ? rx_sel : tx_sel;

    // busy gates the lanes, so only the latched master ever sees non-zero fields
    assign bus.address_m      = busy ? (NUM_MASTERS*ADDR_LEN)'(sh_addr) << (sel*ADDR_LEN) : '0;
    assign bus.data_m         = (busy && !sh_read) ? (NUM_MASTERS*DATA_LEN)'(sh_data) << (sel*DATA_LEN) : '0;
    assign bus.burst_num_m    = busy ? (NUM_MASTERS*BURST_LEN)'(sh_burst) << (sel*BURST_LEN) : '0;
    assign bus.slave_select_m = busy ? (NUM_MASTERS*SLAVE_LEN)'(sh_slave) << (sel*SLAVE_LEN) : '0;
    assign bus.instruction_m  = busy ? (NUM_MASTERS*2)'(sh_read ? INSTR_READ : INSTR_WRITE) << (sel*2)
                                     : {NUM_MASTERS{INSTR_IDLE}};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            sh_addr    <= '0;
            sh_data    <= '0;
            sh_burst   <= '0;
            sh_slave   <= '0;
            sh_read    <= 1'b0;
            sh_master  <= '0;
            cnt        <= '0;
            read_data  <= '0;
            beat_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE:
                    if (go_p && !abort_p) begin
                        if (32'(cmd_master) >= NUM_MASTERS) begin
                            error <= 1'b1;
                        end else begin
                            sh_addr    <= cmd_addr;
                            sh_data    <= cmd_data;
                            sh_burst   <= cmd_burst;
                            sh_slave   <= cmd_slave;
                            sh_read    <= cmd_read;
                            sh_master  <= cmd_master;
                            beat_count <= '0;
                            error      <= 1'b0;
                            busy       <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                ISSUE:
                    if (abort_p) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt   <= '0;
                        state <= sh_read ? WAIT_RD : WAIT_WR;
                    end
                default:
                    if (abort_p) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (state == WAIT_RD && nrx_sel) begin
                            read_data  <= nrx_data;
                            beat_count <= beat_count + BURST_LEN'(~&beat_count);
                        end
                        // a completion strobe on the last allowed cycle beats the timeout
                        if (fin) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (cnt == CNT_LAST) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
            endcase
        end
endmodule

// File: tb/tb_cmd_issuer.sv
// tb_cmd_issuer: directed stimulus against cmd_issuer, checked every cycle by a transaction-level model
module tb_cmd_issuer;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] cmd_addr = '0;
    logic [7:0]  cmd_data = '0;
    logic [11:0] cmd_burst = '0;
    logic [1:0]  cmd_slave = '0;
    logic        cmd_read = 1'b0;
    logic        cmd_master = 1'b0;
    logic [1:0]  cmd_master2 = '0;
    logic        btn_go = 1'b0, btn_abort = 1'b0, btn_go2 = 1'b0;

    logic [7:0]  read_data, read_data2;
    logic [11:0] beat_count, beat_count2;
    logic        busy, done, error, busy2, done2, error2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmd_issuer_if #(.NUM_MASTERS(2)) bus ();
    cmd_issuer_if #(.NUM_MASTERS(3)) bus2 ();

    assign bus2.tx_done_m  = '0;
    assign bus2.rx_done_m  = '0;
    assign bus2.new_rx_m   = '0;
    assign bus2.new_data_m = '0;

    cmd_issuer #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_burst(cmd_burst),
        .cmd_slave(cmd_slave), .cmd_read(cmd_read), .cmd_master(cmd_master), .btn_go(btn_go),
        .btn_abort(btn_abort), .bus(bus), .read_data(read_data), .beat_count(beat_count),
        .busy(busy), .done(done), .error(error)
    );

    cmd_issuer #(.NUM_MASTERS(3), .TIMEOUT_CYCLES(TO)) dut2 (
        .clk(clk), .reset(reset), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_burst(cmd_burst),
        .cmd_slave(cmd_slave), .cmd_read(cmd_read), .cmd_master(cmd_master2), .btn_go(btn_go2),
        .btn_abort(1'b0), .bus(bus2), .read_data(read_data2), .beat_count(beat_count2),
        .busy(busy2), .done(done2), .error(error2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // model: one command record, whether it is in its first (issue) cycle, and how long it has waited
    logic        m_busy = 0, m_issue = 0, m_err = 0, m_done = 0, m_read = 0, m_master = 0;
    logic [11:0] m_addr = 0, m_burst = 0, m_bc = 0;
    logic [7:0]  m_data = 0, m_rd = 0;
    logic [1:0]  m_slave = 0;
    int          m_wait = 0;
    logic [3:0]  gh = 0, ah = 0;
    logic        go_now, ab_now;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            {m_busy, m_issue, m_err, m_done, m_read, m_master} = '0;
            {m_addr, m_burst, m_bc, m_data, m_rd, m_slave} = '0;
            m_wait = 0; gh = 0; ah = 0;
        end else begin
            // a button press acts on the fourth clock edge after it is first sampled high
            go_now = gh[2] & ~gh[3];
            ab_now = ah[2] & ~ah[3];
            gh = {gh[2:0], btn_go};
            ah = {ah[2:0], btn_abort};
            m_done = 0;
            if (!m_busy) begin
                if (go_now && !ab_now) begin
                    if (int'(cmd_master) >= 2) m_err = 1;
                    else begin
                        m_addr = cmd_addr; m_data = cmd_data; m_burst = cmd_burst;
                        m_slave = cmd_slave; m_read = cmd_read; m_master = cmd_master;
                        m_bc = 0; m_err = 0; m_busy = 1; m_issue = 1; m_wait = 0;
                    end
                end
            end else if (ab_now) m_busy = 0;
            else if (m_issue) m_issue = 0;
            else begin
                if (m_read && bus.new_rx_m[m_master]) begin
                    m_rd = bus.new_data_m[int'(m_master)*8 +: 8];
                    if (m_bc != 12'hFFF) m_bc = m_bc + 1;
                end
                if (m_read ? bus.rx_done_m[m_master] : bus.tx_done_m[m_master]) begin
                    m_done = 1; m_busy = 0;
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin m_err = 1; m_busy = 0; end
                end
            end
        end
    end

    logic [23:0] e_addr, e_burst;
    logic [15:0] e_data;
    logic [3:0]  e_slave, e_instr;

    initial forever begin
        @(posedge clk);
        #1;
        e_addr = '0; e_burst = '0; e_data = '0; e_slave = '0; e_instr = '0;
        if (m_busy) begin
            e_addr[int'(m_master)*12 +: 12] = m_addr;
            e_burst[int'(m_master)*12 +: 12] = m_burst;
            e_slave[int'(m_master)*2 +: 2] = m_slave;
            e_instr[int'(m_master)*2 +: 2] = {1'b1, m_read};
            e_data[int'(m_master)*8 +: 8] = m_read ? 8'h00 : m_data;
        end
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("error", error, m_err);
        chk("read_data", read_data, m_rd);
        chk("beat_count", beat_count, m_bc);
        chk("address_m", bus.address_m, e_addr);
        chk("data_m", bus.data_m, e_data);
        chk("burst_num_m", bus.burst_num_m, e_burst);
        chk("slave_select_m", bus.slave_select_m, e_slave);
        chk("instruction_m", bus.instruction_m, e_instr);
    end

    initial begin
        bus.tx_done_m = '0; bus.rx_done_m = '0; bus.new_rx_m = '0; bus.new_data_m = '0;
        tick(2);
        chk("reset busy", busy, 0);
        chk("reset instr", bus.instruction_m, 0);
        chk("reset error", error, 0);
        reset = 0;
        tick(2);

        // write on master 1
        cmd_master = 1; cmd_addr = 12'h005; cmd_data = 8'hA3; cmd_slave = 2; cmd_burst = 12'd1;
        cmd_read = 0; btn_go = 1;
        tick(3);
        chk("go latency", busy, 0);
        tick(1);
        chk("wr instr", bus.instruction_m, 4'b1000);
        chk("wr addr", bus.address_m, 24'h005000);
        chk("wr data", bus.data_m, 16'hA300);
        chk("wr slave", bus.slave_select_m, 4'b1000);
        btn_go = 0; cmd_addr = 12'hFFF;
        tick(1);
        chk("wr addr held", bus.address_m, 24'h005000);
        bus.tx_done_m = 2'b01;
        tick(1);
        chk("wr other done ignored", busy, 1);
        bus.tx_done_m = 2'b10;
        tick(1);
        chk("wr done", done, 1);
        chk("wr outputs zero", bus.instruction_m, 0);
        bus.tx_done_m = 0;
        tick(1);
        chk("wr done one cycle", done, 0);

        // read burst of 3 on master 0, last beat together with rx_done
        cmd_master = 0; cmd_read = 1; cmd_burst = 12'd3; cmd_addr = 12'h123; cmd_slave = 1;
        cmd_data = 8'h5A; btn_go = 1;
        tick(4);
        chk("rd instr", bus.instruction_m, 4'b0011);
        chk("rd data zero", bus.data_m, 0);
        chk("rd burst", bus.burst_num_m, 24'h000003);
        btn_go = 0;
        tick(1);
        bus.new_rx_m = 2'b01; bus.new_data_m = 16'h0011;
        tick(1);
        chk("rd beat1", read_data, 8'h11);
        bus.new_rx_m = 2'b10; bus.new_data_m = 16'h9900;
        tick(1);
        chk("rd other beat ignored", beat_count, 1);
        bus.new_rx_m = 2'b01; bus.new_data_m = 16'h0022;
        tick(1);
        bus.new_data_m = 16'h0033; bus.rx_done_m = 2'b01;
        tick(1);
        chk("rd last data", read_data, 8'h33);
        chk("rd beats", beat_count, 3);
        chk("rd done", done, 1);
        bus.new_rx_m = 0; bus.rx_done_m = 0; bus.new_data_m = 0;
        tick(1);

        // read with no response times out
        btn_go = 1;
        tick(4);
        btn_go = 0;
        tick(TO);
        chk("to still busy", busy, 1);
        tick(1);
        chk("to error", error, 1);
        chk("to idle", busy, 0);
        chk("to no done", done, 0);
        tick(2);

        // write, go while busy, abort, then go+abort together
        cmd_read = 0; cmd_data = 8'h3C; btn_go = 1;
        tick(4);
        chk("go clears error", error, 0);
        chk("ab instr", bus.instruction_m, 4'b0010);
        btn_go = 0;
        tick(2);
        btn_go = 1;
        tick(4);
        chk("go while busy ignored", busy, 1);
        btn_go = 0; btn_abort = 1;
        tick(4);
        chk("abort idle", busy, 0);
        chk("abort no done", done, 0);
        chk("abort instr", bus.instruction_m, 0);
        btn_abort = 0;
        tick(4);
        btn_go = 1; btn_abort = 1;
        tick(4);
        chk("go+abort no issue", busy, 0);
        tick(2);
        chk("go+abort instr", bus.instruction_m, 0);
        btn_go = 0; btn_abort = 0;
        tick(4);

        // asynchronous reset mid read
        cmd_read = 1; cmd_master = 1; cmd_addr = 12'h0AB; btn_go = 1;
        tick(4);
        btn_go = 0;
        tick(1);
        bus.new_rx_m = 2'b10; bus.new_data_m = 16'h4400;
        tick(1);
        chk("mid beat", read_data, 8'h44);
        bus.new_rx_m = 0;
        #2 reset = 1;
        #1;
        chk("async busy", busy, 0);
        chk("async instr", bus.instruction_m, 0);
        chk("async addr", bus.address_m, 0);
        chk("async read_data", read_data, 0);
        chk("async beats", beat_count, 0);
        @(negedge clk);
        reset = 0;
        tick(2);

        // bad master index on a three-master issuer
        cmd_master2 = 2'd3; cmd_read = 0; btn_go2 = 1;
        tick(4);
        chk("bad idx error", error2, 1);
        chk("bad idx busy", busy2, 0);
        chk("bad idx instr", bus2.instruction_m, 0);
        btn_go2 = 0;
        tick(2);
        cmd_master2 = 2'd2; btn_go2 = 1;
        tick(4);
        chk("idx2 clears error", error2, 0);
        chk("idx2 instr", bus2.instruction_m, 6'b100000);
        btn_go2 = 0;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
